// File: rtl/spi_readout_fifo.sv
// -----------------------------------------------------------------------------
// spi_readout_fifo
//
// Byte FIFO that buffers a producer stream (camera readout, debug data) in the
// SPI clock domain and drains it to the host through one response slot of
// spi_peripheral. Three opcodes are decoded at the start of a transaction:
//   DATA_ADDRESS  : burst read, every operand byte boundary pops one entry
//   LEVEL_ADDRESS : returns the fill level captured when the opcode arrived
//   CLEAR_ADDRESS : flushes the FIFO and clears the sticky overflow flag
//
// Ports
//   clock_in           : SPI-domain clock
//   reset_in           : synchronous, active-high reset
//   write_data_in      : producer byte
//   write_valid_in     : producer byte is valid
//   write_ready_out    : FIFO accepts the byte this cycle (0 while full/reset)
//   opcode_in          : opcode from spi_peripheral
//   opcode_valid_in    : high for the whole transaction after the opcode byte
//   operand_valid_in   : toggles/pulses at each operand byte boundary
//   operand_count_in   : operand index (informational only)
//   response_out       : registered response byte
//   response_valid_out : this block currently owns the response path
//   level_out          : current entry count (registered)
//   overflow_out       : sticky, a write was attempted while full
// -----------------------------------------------------------------------------
module spi_readout_fifo #(
    parameter logic [7:0] DATA_ADDRESS  = 8'h22,
    parameter logic [7:0] LEVEL_ADDRESS = 8'h23,
    parameter logic [7:0] CLEAR_ADDRESS = 8'h24,
    parameter int         DEPTH         = 16
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic [7:0]                 write_data_in,
    input  logic                       write_valid_in,
    output logic                       write_ready_out,
    input  logic [7:0]                 opcode_in,
    input  logic                       opcode_valid_in,
    input  logic                       operand_valid_in,
    input  logic [31:0]                operand_count_in,
    output logic [7:0]                 response_out,
    output logic                       response_valid_out,
    output logic [$clog2(DEPTH):0]     level_out,
    output logic                       overflow_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Strobe indices for the edge detectors below.
    localparam int STB_OPCODE  = 0;
    localparam int STB_OPERAND = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_LEVEL
    } state_t;

    // The operand index is carried by the peripheral for other responders;
    // this block counts byte boundaries by edge instead.
    logic unused_operand_count;
    assign unused_operand_count = ^operand_count_in;

    // -------------------------------------------------------------------------
    // Edge detection on the transaction strobes. Each strobe is registered
    // once (cur) and once more (prev); a rise is cur=1, prev=0. Both reset to
    // 0, so a strobe still held high when reset is released reads as a rise.
    // -------------------------------------------------------------------------
    logic [1:0] strobe_raw;
    logic [1:0] strobe_level;
    logic [1:0] strobe_rise;

    assign strobe_raw = {operand_valid_in, opcode_valid_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            logic cur_reg;
            logic prev_reg;

            always_ff @(posedge clock_in) begin
                if (reset_in) begin
                    cur_reg  <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    cur_reg  <= strobe_raw[gi];
                    prev_reg <= cur_reg;
                end
            end

            assign strobe_level[gi] = cur_reg;
            assign strobe_rise[gi]  = cur_reg & ~prev_reg;
        end
    endgenerate

    // Opcode is captured alongside the registered opcode strobe so the decode
    // lines up with the detected rise.
    logic [7:0] opcode_reg;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            opcode_reg <= 8'h00;
        end else begin
            opcode_reg <= opcode_in;
        end
    end

    logic opcode_level;
    logic opcode_rise;
    logic operand_rise;

    assign opcode_level = strobe_level[STB_OPCODE];
    assign opcode_rise  = strobe_rise[STB_OPCODE];
    assign operand_rise = strobe_rise[STB_OPERAND];

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    state_t             state_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic               head_valid_reg;
    logic [7:0]         ram_rd_data_reg;

    logic [PTR_W-1:0]   rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [CNT_W-1:0]   count_next;
    logic               overflow_next;
    logic               head_valid_next;

    logic full;
    logic empty;
    logic clear_fire;
    logic push;
    logic pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

    assign clear_fire = (state_reg == ST_IDLE) && opcode_rise &&
                        (opcode_reg == CLEAR_ADDRESS);

    // Ready depends only on the registered count, so a pop while full frees a
    // slot for the following cycle rather than the current one.
    assign write_ready_out = !full && !reset_in;

    // A clear on the same edge discards the incoming byte.
    assign push = write_valid_in && write_ready_out && !clear_fire;

    assign pop = (state_reg == ST_DATA) && opcode_level && operand_rise && !empty;

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (clear_fire) begin
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
            if (write_valid_in && full) begin
                overflow_next = 1'b1;
            end
        end
    end

    // The RAM read below is read-before-write: if the address being read is
    // written on the same edge, the captured data is stale. Such a read is
    // marked invalid and the correct byte arrives one cycle later.
    assign head_valid_next = (count_next != '0) &&
                             !(push && (rd_ptr_next == wr_ptr_reg));

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            head_valid_reg <= 1'b0;
        end else begin
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            head_valid_reg <= head_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: registered read addressed by the next read pointer, so the new
    // head is available on the same edge the pointer advances.
    // -------------------------------------------------------------------------
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[wr_ptr_reg] <= write_data_in;
        end
        ram_rd_data_reg <= mem[rd_ptr_next];
    end

    logic [7:0] head_byte;
    assign head_byte = head_valid_reg ? ram_rd_data_reg : 8'h00;

    // -------------------------------------------------------------------------
    // Transaction FSM with registered response outputs
    // -------------------------------------------------------------------------
    logic [7:0] response_reg;
    logic       response_valid_reg;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg          <= ST_IDLE;
            response_reg       <= 8'h00;
            response_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    response_reg       <= 8'h00;
                    response_valid_reg <= 1'b0;
                    if (opcode_rise) begin
                        if (opcode_reg == DATA_ADDRESS) begin
                            state_reg          <= ST_DATA;
                            response_reg       <= head_byte;
                            response_valid_reg <= 1'b1;
                        end else if (opcode_reg == LEVEL_ADDRESS) begin
                            state_reg          <= ST_LEVEL;
                            response_reg       <= 8'(count_reg);
                            response_valid_reg <= 1'b1;
                        end
                        // Clear is handled by the FIFO logic; any other
                        // opcode belongs to a different responder.
                    end
                end

                ST_DATA: begin
                    if (!opcode_level) begin
                        state_reg          <= ST_IDLE;
                        response_reg       <= 8'h00;
                        response_valid_reg <= 1'b0;
                    end else begin
                        response_reg       <= head_byte;
                        response_valid_reg <= 1'b1;
                    end
                end

                ST_LEVEL: begin
                    // The snapshot is held; operand edges do not refresh it.
                    if (!opcode_level) begin
                        state_reg          <= ST_IDLE;
                        response_reg       <= 8'h00;
                        response_valid_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg          <= ST_IDLE;
                    response_reg       <= 8'h00;
                    response_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign response_out       = response_reg;
    assign response_valid_out = response_valid_reg;
    assign level_out          = count_reg;
    assign overflow_out       = overflow_reg;

endmodule

// File: doc/spi_readout_fifo.md
# spi_readout_fifo

Byte FIFO that buffers a producer stream (camera readout, debug data) in the SPI clock domain and drains it to the host through the SPI peripheral's response path. The block decodes opcodes from `spi_peripheral` and serves three registers: data read with auto-pop, fill-level read, and clear. It drives one `response_N_in`/`response_N_valid_in` pair of `spi_peripheral`, alongside the chip-ID and camera responders.

## Interface
- `DATA_ADDRESS`, 'h22: opcode for a burst read; each byte clocked out pops one entry.
- `LEVEL_ADDRESS`, 'h23: opcode that returns the fill level.
- `CLEAR_ADDRESS`, 'h24: opcode that flushes the FIFO and clears overflow.
- `DEPTH`, 16: entries; power of two, 4..128.

- `clock_in` in 1: SPI-domain clock (`clock_spi`).
- `reset_in` in 1: synchronous, active-high reset.
- `write_data_in` in 8: producer byte.
- `write_valid_in` in 1: producer byte is valid.
- `write_ready_out` out 1: FIFO accepts the byte this cycle.
- `opcode_in` in 8: opcode from `spi_peripheral`.
- `opcode_valid_in` in 1: high for the whole transaction after the opcode byte.
- `operand_valid_in` in 1: pulses or level per operand byte boundary.
- `operand_count_in` in 32: operand index; informational, unused for control.
- `response_out` out 8: registered response byte.
- `response_valid_out` out 1: this block owns the response path.
- `level_out` out $clog2(DEPTH)+1: current entry count.
- `overflow_out` out 1: sticky; a write was attempted while full.

## Operation
- Storage is DEPTH×8, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. A count register of $clog2(DEPTH)+1 bits holds the fill; full when count==DEPTH, empty when count==0.
- Push: `write_valid_in && write_ready_out`. `write_ready_out` = !full, and is 0 while `reset_in` is high.
- Write while full sets `overflow_out`. The byte is dropped and the pointers do not change.
- Edge detect: `opcode_valid_in` and `operand_valid_in` are registered; the previous-value registers reset to 0. A rise is current=1 and previous=0.
- The FSM has states IDLE, DATA and LEVEL.
- IDLE, on an `opcode_valid_in` rise:
  - opcode==DATA_ADDRESS → DATA.
  - opcode==LEVEL_ADDRESS → LEVEL; snapshot count into `response_out`.
  - opcode==CLEAR_ADDRESS → pointers, count and overflow go to 0; stay in IDLE.
  - any other opcode → stay in IDLE; `response_valid_out` stays 0.
- DATA:
  - `response_valid_out`=1.
  - `response_out` = head byte when not empty, else 'h00.
  - An `operand_valid_in` rise pops one entry if not empty. If empty there is no pop and no pointer change.
- LEVEL: `response_valid_out`=1 and `response_out` holds the snapshot. Operand edges are ignored.
- DATA/LEVEL → IDLE when `opcode_valid_in` is low. `response_valid_out` goes to 0 and `response_out` goes to 'h00.
- Push and pop in the same cycle: both happen and count is unchanged. This is legal when full (pop frees a slot, but ready was already low, so no push) and when empty (no pop).
- Clear in the same cycle as a push: clear wins and the pushed byte is discarded.
- `reset_in` mid-transaction: next cycle the FSM is IDLE and all outputs are at reset values. A subsequent rise of `opcode_valid_in` is required to re-enter DATA/LEVEL; a level still high after reset counts as a rise.

## Timing
- Reset values:
  - `response_out`='h00, `response_valid_out`=0, `overflow_out`=0, `level_out`=0.
  - `write_ready_out`=0 during reset, 1 on the first cycle after it.
  - State IDLE, pointers 0.
- An `opcode_valid_in` rise sampled at edge N → state, `response_valid_out` and `response_out` valid after edge N+1.
- An `operand_valid_in` rise sampled at edge M → pop at edge M+1; `response_out` shows the new head after edge M+2.
- A push into an empty FIFO while in DATA → `response_out` shows that byte 2 edges after the push edge.
- `level_out` is registered and updates on the same edge as the count.
- Clear takes effect 1 edge after the rise is registered.

## Test plan
- Push 'hA1,'hB2,'hC3; DATA transaction with 3 operand edges → response 'hA1,'hB2,'hC3; `level_out` ends at 0. A 4th edge → 'h00 and level stays 0.
- Push 16 bytes 'h00..'h0F, then a 17th with DEPTH=16 → `write_ready_out`=0 after the 16th push, `overflow_out`=1. A LEVEL read returns 'h10.
- Fill to 16, DATA pop 1 while pushing 'hFF in the same cycle → level 15 after the pop, then 16 after the next accepted push. The final byte read is 'hFF (verifies wrap-around).
- CLEAR opcode with 5 entries and overflow set → `level_out`=0 and `overflow_out`=0. A push coinciding with the clear cycle is not stored.
- Unknown opcode 'h55 → `response_valid_out` stays 0 for the whole transaction and no pop occurs.
- Assert `reset_in` mid-DATA with 3 entries → next cycle `response_valid_out`=0 and `level_out`=0. A new DATA read returns 'h00.
